// File: rtl/dmem_arbiter.sv
// Shares the data memory port between the CPU load/store path and the I/O master.
// CPU has priority, starvation aging lets I/O through, and lock mode gives I/O bursts.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        io_req,
  input  logic        io_we,
  input  logic        io_lock,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic        io_gnt,
  output logic        io_rvalid,
  output logic [31:0] io_rdata,
  output logic        lock_active,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic {ARB, LOCK} state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == SMAX);

  always_comb begin
    io_gnt  = 1'b0;
    cpu_gnt = 1'b0;
    state_d = state_q;
    unique case (state_q)
      ARB: begin
        io_gnt  = io_req & (~cpu_req | starved);
        cpu_gnt = cpu_req & ~io_gnt;
        if (io_gnt & io_lock)
          state_d = LOCK;
      end
      LOCK: begin
        io_gnt = io_req;
        if (!io_lock)
          state_d = ARB;
      end
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (1'b1)
      cpu_gnt: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_read  = ~cpu_we;
        mem_write = cpu_we;
      end
      io_gnt: begin
        mem_addr  = io_addr;
        mem_wdata = io_wdata;
        mem_read  = ~io_we;
        mem_write = io_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ARB;
      starve_cnt <= '0;
      cpu_rvalid <= 1'b0;
      io_rvalid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      io_rvalid  <= io_gnt & ~io_we;
      // Aging only counts denied cycles in ARB; lock mode never ages.
      if (state_q == LOCK || io_gnt || !io_req)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign cpu_stall   = cpu_req & ~cpu_gnt;
  assign lock_active = (state_q == LOCK);
  assign cpu_rdata   = cpu_rvalid ? mem_rdata : '0;
  assign io_rdata    = io_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural ownership/memory model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        io_req, io_we, io_lock;
  logic [31:0] io_addr, io_wdata;
  logic        io_gnt, io_rvalid;
  logic [31:0] io_rdata;
  logic        lock_active;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .Clock(clk), .Reset(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_lock(io_lock),
    .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .lock_active(lock_active),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  // Memory: 64 words indexed by low address bits; garbage when not reading.
  logic [31:0] tmem [64];
  logic [31:0] rd_q;
  assign mem_rdata = rd_q;
  initial for (int i = 0; i < 64; i++) tmem[i] = 32'h0;
  always @(posedge clk) begin
    if (mem_write) tmem[mem_addr[5:0]] <= mem_wdata;
    rd_q <= mem_read ? tmem[mem_addr[5:0]] : $urandom;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how long I/O has waited, what reads return.
  bit          m_locked = 0;
  int          m_waited = 0;
  bit          m_pcpu = 0;
  bit          m_pio = 0;
  logic [31:0] m_pval = 0;
  logic [31:0] mm [64];
  initial for (int i = 0; i < 64; i++) mm[i] = 32'h0;

  always @(negedge clk) begin
    if (armed) begin
      bit e_io, e_cpu, e_rd, e_wr;
      logic [31:0] e_a, e_d;
      if (m_locked) e_io = io_req;
      else e_io = io_req && (!cpu_req || m_waited >= SMAX);
      e_cpu = !m_locked && cpu_req && !e_io;
      e_a = 0; e_d = 0; e_rd = 0; e_wr = 0;
      if (e_cpu) begin
        e_a = cpu_addr; e_d = cpu_wdata; e_wr = cpu_we; e_rd = !cpu_we;
      end else if (e_io) begin
        e_a = io_addr; e_d = io_wdata; e_wr = io_we; e_rd = !io_we;
      end
      chk("grants", {28'h0, cpu_gnt, io_gnt, cpu_stall, lock_active},
          {28'h0, e_cpu, e_io, cpu_req && !e_cpu, m_locked});
      chk("strobes", {30'h0, mem_read, mem_write}, {30'h0, e_rd, e_wr});
      chk("mem_addr", mem_addr, e_a);
      chk("mem_wdata", mem_wdata, e_d);
      chk("rvalid", {30'h0, cpu_rvalid, io_rvalid}, {30'h0, m_pcpu, m_pio});
      chk("cpu_rdata", cpu_rdata, m_pcpu ? m_pval : 32'h0);
      chk("io_rdata", io_rdata, m_pio ? m_pval : 32'h0);
      m_pval = mm[e_a[5:0]];
      if (e_wr) mm[e_a[5:0]] = e_d;
      if (rst) begin
        m_locked = 0; m_waited = 0; m_pcpu = 0; m_pio = 0;
      end else begin
        if (m_locked || !io_req || e_io) m_waited = 0;
        else if (m_waited < SMAX) m_waited++;
        m_locked = m_locked ? io_lock : (e_io && io_lock);
        m_pcpu = e_cpu && e_rd;
        m_pio = e_io && e_rd;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    io_req = 0; io_we = 0; io_lock = 0; io_addr = 0; io_wdata = 0;
  endtask

  initial begin
    int i;
    int n;
    idle();
    rst = 1;
    cpu_req = 1; io_req = 1; io_lock = 1;
    cyc();
    armed = 1;
    cyc();
    rst = 0;
    #2;
    chk("rst_rvalid", {30'h0, cpu_rvalid, io_rvalid}, 32'h0);
    chk("rst_lock", {31'h0, lock_active}, 32'h0);
    chk("rst_first_cpu_gnt", {31'h0, cpu_gnt}, 32'h1);

    cyc(); idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #2;
    chk("cpu_wr_strobe", {30'h0, mem_write, mem_read}, 32'h2);
    chk("cpu_wr_addr", mem_addr, 32'h10);
    cyc();
    cpu_we = 0; cpu_wdata = 0;
    #2;
    chk("cpu_rd_gnt", {31'h0, cpu_gnt}, 32'h1);
    cyc(); idle(); #2;
    chk("cpu_rvalid", {31'h0, cpu_rvalid}, 32'h1);
    chk("cpu_rdata_lit", cpu_rdata, 32'hDEADBEEF);

    // Continuous contention: 4 CPU grants then one I/O grant, repeating.
    for (int k = 0; k < 10; k++) begin
      cyc();
      cpu_req = 1; io_req = 1; cpu_addr = 32'h1; io_addr = 32'h2;
      #2;
      chk("contend_io_gnt", {31'h0, io_gnt}, {31'h0, (k % 5) == 4});
      chk("contend_stall", {31'h0, cpu_stall}, {31'h0, (k % 5) == 4});
    end
    cyc(); idle();

    // Lock burst: writes land on 0x20..0x27 once I/O is granted.
    i = 0; n = 0;
    while (i < 8 && n < 30) begin
      cyc();
      cpu_req = 1; cpu_we = 0; cpu_addr = 0;
      io_req = 1; io_we = 1; io_lock = 1;
      io_addr = 32'h20 + i; io_wdata = 32'hA5000000 | i;
      #2;
      if (io_gnt) begin
        chk("lock_stall", {31'h0, cpu_stall}, 32'h1);
        chk("lock_active", {31'h0, lock_active}, {31'h0, i > 0});
        i++;
      end
      n++;
    end
    chk("lock_burst_done", i, 8);
    cyc();
    io_req = 0; io_lock = 0; io_we = 0;
    #2;
    chk("unlock_cycle_io", {30'h0, cpu_gnt, lock_active}, 32'h1);
    cyc(); #2;
    chk("unlock_cpu_gnt", {30'h0, cpu_gnt, lock_active}, 32'h2);

    cyc(); idle();
    io_req = 1; io_addr = 32'h20;
    #2;
    chk("io_rd_gnt", {31'h0, io_gnt}, 32'h1);
    cyc(); idle(); #2;
    chk("io_rvalid", {30'h0, io_rvalid, cpu_rvalid}, 32'h2);
    chk("io_rdata_lit", io_rdata, 32'hA5000000);

    // Reset in the middle of a locked read burst.
    cyc(); io_req = 1; io_lock = 1; io_addr = 32'h21;
    cyc(); #2;
    chk("lock_again", {31'h0, lock_active}, 32'h1);
    cyc(); rst = 1;
    cyc(); rst = 0; cpu_req = 1;
    #2;
    chk("rst_lock_state", {30'h0, lock_active, io_rvalid}, 32'h0);
    chk("rst_lock_cpu_gnt", {31'h0, cpu_gnt}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      cyc(); #2;
      chk("rst_starve_cleared", {31'h0, io_gnt}, {31'h0, k == 3});
    end

    for (int k = 0; k < 3000; k++) begin
      cyc();
      rst = ($urandom_range(63) == 0);
      cpu_req = ($urandom_range(3) != 0);
      cpu_we = $urandom_range(1);
      cpu_addr = $urandom_range(63);
      cpu_wdata = $urandom;
      io_req = ($urandom_range(2) != 0);
      io_we = $urandom_range(1);
      io_lock = ($urandom_range(3) == 0);
      io_addr = $urandom_range(63);
      io_wdata = $urandom;
    end
    cyc(); idle();
    cyc(); cyc();
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
